// File: rtl/ssp_rx_deserializer_fifo.sv
// ssp_rx_deserializer_fifo: frames SSP serial bits into words and buffers them in a small RX FIFO
// drained by valid/ready; flags words lost to a full FIFO with a sticky overrun bit.
module ssp_rx_deserializer_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter bit LSB_FIRST  = 1'b0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                 i_SSPCLKIN,
   input  logic                                 i_CLEAR_B,
   input  logic                                 i_SSPFSSIN,
   input  logic                                 i_SSPRXD,
   output logic [DATA_WIDTH-1:0]                o_RXDATA,
   output logic                                 o_RXVALID,
   input  logic                                 i_RXREADY,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      o_LEVEL,
   output logic                                 o_OVERRUN,
   input  logic                                 i_OVR_CLR
);
   localparam int CW = $clog2(DATA_WIDTH);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH+1);
   typedef enum logic {IDLE, SHIFT} state_e;
   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d, idx;
   logic [DATA_WIDTH-1:0] sr_q, sr_d, word;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0]         lvl_q, lvl_d;
   logic                  ovr_q, ovr_d;
   logic                  last, reload, pop, full, accept;
   always_comb begin
      idx     = LSB_FIRST ? CW'(DATA_WIDTH-1) - cnt_q : cnt_q;
      word    = sr_q;
      word[idx] = i_SSPRXD;
      last    = (state_q == SHIFT) && (cnt_q == '0);
      reload  = ((state_q == IDLE) || last) && i_SSPFSSIN;
      state_d = ((state_q == IDLE) || last) ? (i_SSPFSSIN ? SHIFT : IDLE) : SHIFT;
      cnt_d   = reload ? CW'(DATA_WIDTH-1) : ((state_q == SHIFT) && !last) ? cnt_q - 1'b1 : cnt_q;
      // cleared on the push edge so the next word starts from all zeros
      sr_d    = last ? '0 : (state_q == SHIFT) ? word : sr_q;
      pop     = o_RXVALID && i_RXREADY;
      full    = lvl_q == LW'(FIFO_DEPTH);
      accept  = last && (!full || pop);
      wr_d    = wr_q + PW'(accept);
      rd_d    = rd_q + PW'(pop);
      lvl_d   = lvl_q + LW'(accept) - LW'(pop);
      ovr_d   = (last && !accept) || (ovr_q && !i_OVR_CLR);
   end
   always_ff @(posedge i_SSPCLKIN or negedge i_CLEAR_B) begin
      if (!i_CLEAR_B) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         lvl_q   <= '0;
         ovr_q   <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         lvl_q   <= lvl_d;
         ovr_q   <= ovr_d;
         if (accept) mem_q[wr_q] <= word;
      end
   end
   assign o_RXDATA  = mem_q[rd_q];
   assign o_RXVALID = lvl_q != '0;
   assign o_LEVEL   = lvl_q;
   assign o_OVERRUN = ovr_q;
endmodule
